// File: rtl/sysmon_drp_pkg.sv
// sysmon_drp_pkg: shared constants and types for the SYSMON DRP responder.
//   - DRP register map bases and fixed addresses
//   - reset defaults of the configuration bank
//   - responder FSM state and address-region enums
//   - addr_region(): classifies a DRP address into its register bank
package sysmon_drp_pkg;

  localparam int STATUS_BASE = 'h00;
  localparam int CFG_BASE    = 'h40;
  localparam int ALM_BASE    = 'h50;
  localparam int TEMP_ADDR   = 'h00;
  localparam int CTRL_ADDR   = 'h40;
  localparam int SEQ_ADDR    = 'h46;

  localparam int STATUS_DEPTH = 64;
  localparam int CFG_DEPTH    = 16;
  localparam int ALM_DEPTH    = 16;

  // Power-on contents of config registers 0x40..0x4F, index 0 = 0x40.
  localparam logic [15:0] CFG_RST [CFG_DEPTH] = '{
    16'h9000, 16'h2FDC, 16'h0A00, 16'h0000, 16'h0000, 16'h0000, 16'h000F, 16'hFFFF,
    16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  typedef enum logic [1:0] {IDLE, WAIT, RESP} drp_state_e;

  typedef enum logic [1:0] {REG_STATUS, REG_CFG, REG_ALM, REG_NONE} drp_region_e;

  // Upper address bits select the bank; anything outside the three banks is unmapped.
  function automatic drp_region_e addr_region(input logic [15:0] addr);
    drp_region_e region;
    region = REG_NONE;
    if (addr[15:6] == 10'(STATUS_BASE >> 6))   region = REG_STATUS;
    else if (addr[15:4] == 12'(CFG_BASE >> 4)) region = REG_CFG;
    else if (addr[15:4] == 12'(ALM_BASE >> 4)) region = REG_ALM;
    return region;
  endfunction

endpackage

// File: rtl/sysmon_drp_regfile.sv
// sysmon_drp_regfile: SYSMON register array for the DRP responder.
//   Build option: define SYSMON_DRP_ALARM_EN to implement alarm limits 0x50..0x5F
//   and the over-temperature alarm; otherwise 0x50..0x5F are unmapped, alarm = 0.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   drp_we/drp_addr/drp_wdata      DRP write port (config / alarm banks only)
//   conv_we/conv_ch/conv_data      conversion-result write port (status bank only)
//   rd_addr -> rd_data             combinational read port, unmapped reads 0
//   cfg_ctrl, cfg_seq              live copies of registers 0x40 and 0x46
//   alarm                          registered over-temperature flag
module sysmon_drp_regfile
  import sysmon_drp_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drp_we,
  input  logic [ADDR_W-1:0] drp_addr,
  input  logic [15:0]       drp_wdata,
  input  logic              conv_we,
  input  logic [5:0]        conv_ch,
  input  logic [15:0]       conv_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic [15:0]       cfg_ctrl,
  output logic [15:0]       cfg_seq,
  output logic              alarm
);

  logic [15:0] r_status [STATUS_DEPTH];
  logic [15:0] r_cfg    [CFG_DEPTH];

  drp_region_e w_wr_region;
  drp_region_e w_rd_region;

  assign w_wr_region = addr_region(16'(drp_addr));
  assign w_rd_region = addr_region(16'(rd_addr));

  // NOTE: these arrays are small flop banks, not RAM, so they take an async reset;
  // a reset on an inferred RAM would block RAM mapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STATUS_DEPTH; i++) r_status[i] <= '0;
    end else if (conv_we) begin
      r_status[conv_ch] <= conv_data;
    end
  end

  // DRP writes to the status bank are silently dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CFG_DEPTH; i++) r_cfg[i] <= CFG_RST[i];
    end else if (drp_we && (w_wr_region == REG_CFG)) begin
      r_cfg[drp_addr[3:0]] <= drp_wdata;
    end
  end

  assign cfg_ctrl = r_cfg[CTRL_ADDR - CFG_BASE];
  assign cfg_seq  = r_cfg[SEQ_ADDR - CFG_BASE];

`ifdef SYSMON_DRP_ALARM_EN
  logic [15:0] r_alm [ALM_DEPTH];
  logic        r_alarm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ALM_DEPTH; i++) r_alm[i] <= '0;
    end else if (drp_we && (w_wr_region == REG_ALM)) begin
      r_alm[drp_addr[3:0]] <= drp_wdata;
    end
  end

  // A zero limit disables the alarm rather than tripping on any non-zero reading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alarm <= 1'b0;
    else        r_alarm <= (r_alm[0] != 16'h0000) &&
                           (r_status[TEMP_ADDR - STATUS_BASE] > r_alm[0]);
  end

  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

  // NOTE: default assignment first so no path through the case can infer a latch.
  always_comb begin
    rd_data = '0;
    case (w_rd_region)
      REG_STATUS: rd_data = r_status[rd_addr[5:0]];
      REG_CFG:    rd_data = r_cfg[rd_addr[3:0]];
`ifdef SYSMON_DRP_ALARM_EN
      REG_ALM:    rd_data = r_alm[rd_addr[3:0]];
`endif
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/sysmon_drp_responder.sv
// sysmon_drp_responder: DRP target emulating the SYSMONE4 register map.
//   Build option: SYSMON_DRP_ALARM_EN (alarm-limit bank and alarm output).
// Ports:
//   clk, rst_n           clock, async-assert active-low reset (release synchronised)
//   den/dwe/daddr/di     DRP request; accepted only in IDLE
//   do_data/drdy         read data (held until next drdy) and completion pulse,
//                        drdy lands RD_LATENCY+1 cycles after the den cycle
//   drp_err              one-cycle pulse for a den dropped while busy
//   conv_eoc/conv_channel/conv_data   conversion result into status[conv_channel]
//   cfg_ctrl, cfg_seq    live copies of registers 0x40 / 0x46
//   alarm                over-temperature flag (0 unless SYSMON_DRP_ALARM_EN)
module sysmon_drp_responder
  import sysmon_drp_pkg::*;
#(
  parameter int RD_LATENCY = 2,  // 1..7
  parameter int ADDR_W     = 8   // 7..16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              den,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [15:0]       di,
  output logic [15:0]       do_data,
  output logic              drdy,
  output logic              drp_err,
  input  logic              conv_eoc,
  input  logic [5:0]        conv_channel,
  input  logic [15:0]       conv_data,
  output logic [15:0]       cfg_ctrl,
  output logic [15:0]       cfg_seq,
  output logic              alarm
);

  drp_state_e  r_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_rdata;
  logic [1:0]  r_rst_sync;
  logic        w_accept;
  logic [15:0] w_rd_data;

  // Reset asserts immediately but its release only enables DRP requests after
  // two clock edges, so a request cannot race the reset deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_accept = den && (r_state == IDLE) && r_rst_sync[1];

  // Reads and writes use the same address on the den cycle: the read samples the
  // array before that edge, so a concurrent conv_eoc or write is not visible.
  sysmon_drp_regfile #(.ADDR_W(ADDR_W)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .drp_we    (w_accept && dwe),
    .drp_addr  (daddr),
    .drp_wdata (di),
    .conv_we   (conv_eoc),
    .conv_ch   (conv_channel),
    .conv_data (conv_data),
    .rd_addr   (daddr),
    .rd_data   (w_rd_data),
    .cfg_ctrl  (cfg_ctrl),
    .cfg_seq   (cfg_seq),
    .alarm     (alarm)
  );

  // WAIT spans RD_LATENCY cycles (count RD_LATENCY-1 down to 0); drdy is registered
  // on entry to RESP so it is high exactly during the RESP cycle. A write returns
  // the register's previous contents on do_data.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      do_data <= '0;
      drdy    <= 1'b0;
      drp_err <= 1'b0;
    end else begin
      drdy    <= 1'b0;
      drp_err <= den && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rdata <= w_rd_data;
            r_cnt   <= 3'(RD_LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            drdy    <= 1'b1;
            do_data <= r_rdata;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysmon_drp_responder.sv
// tb_sysmon_drp_responder: directed + randomized bench for sysmon_drp_responder.
// Keeps a register-map model (plain arrays) and compares every DRP response,
// latency, live config copy and alarm against it.
module tb_sysmon_drp_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        den = 1'b0;
  logic        dwe = 1'b0;
  logic [7:0]  daddr = '0;
  logic [15:0] di = '0;
  logic [15:0] do_data;
  logic        drdy;
  logic        drp_err;
  logic        conv_eoc = 1'b0;
  logic [5:0]  conv_channel = '0;
  logic [15:0] conv_data = '0;
  logic [15:0] cfg_ctrl;
  logic [15:0] cfg_seq;
  logic        alarm;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_status [64];
  logic [15:0] m_cfg    [16];
  logic [15:0] m_alm    [16];

`ifdef SYSMON_DRP_ALARM_EN
  localparam bit ALM_EN = 1'b1;
`else
  localparam bit ALM_EN = 1'b0;
`endif

  sysmon_drp_responder #(.RD_LATENCY(LAT), .ADDR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .den          (den),
    .dwe          (dwe),
    .daddr        (daddr),
    .di           (di),
    .do_data      (do_data),
    .drdy         (drdy),
    .drp_err      (drp_err),
    .conv_eoc     (conv_eoc),
    .conv_channel (conv_channel),
    .conv_data    (conv_data),
    .cfg_ctrl     (cfg_ctrl),
    .cfg_seq      (cfg_seq),
    .alarm        (alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_status[i] = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      m_cfg[i] = 16'h0000;
      m_alm[i] = 16'h0000;
    end
    m_cfg[0] = 16'h9000; m_cfg[1] = 16'h2FDC; m_cfg[2] = 16'h0A00; m_cfg[6] = 16'h000F;
    m_cfg[7] = 16'hFFFF; m_cfg[8] = 16'hFFFF; m_cfg[9] = 16'hFFFF;
  endtask

  function automatic logic [15:0] model_read(input int a);
    if (a < 'h40)                         return m_status[a];
    if (a < 'h50)                         return m_cfg[a - 'h40];
    if (ALM_EN && a < 'h60)               return m_alm[a - 'h50];
    return 16'h0000;
  endfunction

  task automatic model_write(input int a, input logic [15:0] d);
    if (a >= 'h40 && a < 'h50)            m_cfg[a - 'h40] = d;
    else if (ALM_EN && a >= 'h50 && a < 'h60) m_alm[a - 'h50] = d;
  endtask

  function automatic logic model_alarm();
    return ALM_EN && (m_alm[0] != 0) && (m_status[0] > m_alm[0]);
  endfunction

  // ---------------- stimulus tasks ----------------
  // One DRP transaction, optionally with a conversion result in the den cycle.
  task automatic drp_txn(input string tag, input int addr, input logic we,
                         input logic [15:0] wd, input logic ce,
                         input logic [5:0] ch, input logic [15:0] cd);
    logic [15:0] exp;
    int lat;
    exp = model_read(addr);
    @(negedge clk);
    den = 1'b1; dwe = we; daddr = 8'(addr); di = wd;
    conv_eoc = ce; conv_channel = ch; conv_data = cd;
    @(negedge clk);
    den = 1'b0; dwe = 1'b0; conv_eoc = 1'b0;
    if (we) model_write(addr, wd);
    if (ce) m_status[ch] = cd;
    check({tag, " cfg_ctrl"}, cfg_ctrl, m_cfg[0]);
    check({tag, " cfg_seq"}, cfg_seq, m_cfg[6]);
    lat = 1;
    while (drdy !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 16'(lat), 16'(LAT + 1));
    if (!we) check({tag, " rdata"}, do_data, exp);
    @(negedge clk);
    check({tag, " drdy pulse"}, {15'b0, drdy}, 16'h0000);
    check({tag, " alarm"}, {15'b0, alarm}, {15'b0, model_alarm()});
  endtask

  task automatic conv_pulse(input logic [5:0] ch, input logic [15:0] cd);
    @(negedge clk);
    conv_eoc = 1'b1; conv_channel = ch; conv_data = cd;
    @(negedge clk);
    conv_eoc = 1'b0;
    m_status[ch] = cd;
    @(negedge clk);
    check("conv alarm", {15'b0, alarm}, {15'b0, model_alarm()});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n_drdy;
    int n_err;
    logic [15:0] got;
    logic [15:0] exp;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst do_data", do_data, 16'h0000);
    check("rst drdy", {15'b0, drdy}, 16'h0000);
    check("rst drp_err", {15'b0, drp_err}, 16'h0000);
    check("rst alarm", {15'b0, alarm}, 16'h0000);
    check("rst cfg_ctrl", cfg_ctrl, 16'h9000);
    check("rst cfg_seq", cfg_seq, 16'h000F);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Config reset values.
    drp_txn("rd 40", 'h40, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 41", 'h41, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 46", 'h46, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 47", 'h47, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 42", 'h42, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 49", 'h49, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 4a", 'h4A, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);

    // Read sampled on the den cycle, ahead of a same-cycle conversion.
    conv_pulse(6'd16, 16'h1234);
    drp_txn("rd 10 same-cycle conv", 'h10, 1'b0, 16'h0, 1'b1, 6'd16, 16'h5678);
    drp_txn("rd 10 after conv", 'h10, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);

    // Config write and ignored status write.
    drp_txn("wr 40", 'h40, 1'b1, 16'hA5A5, 1'b0, 6'd0, 16'h0);
    drp_txn("wr 05", 'h05, 1'b1, 16'hFFFF, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 05", 'h05, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);

    // den while busy: dropped write to 0x41, one error pulse, one drdy.
    exp = model_read('h40);
    @(negedge clk);
    den = 1'b1; dwe = 1'b0; daddr = 8'h40;
    @(negedge clk);
    den = 1'b1; dwe = 1'b1; daddr = 8'h41; di = 16'hDEAD;
    @(negedge clk);
    den = 1'b0; dwe = 1'b0;
    n_drdy = 0; n_err = 0; got = 16'hXXXX;
    for (int i = 0; i < 10; i++) begin
      if (drp_err === 1'b1) n_err++;
      if (drdy === 1'b1) begin
        n_drdy++;
        got = do_data;
      end
      @(negedge clk);
    end
    check("busy err count", 16'(n_err), 16'd1);
    check("busy drdy count", 16'(n_drdy), 16'd1);
    check("busy rdata", got, exp);
    drp_txn("rd 41 after drop", 'h41, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);

    // Unmapped and optional banks.
    drp_txn("rd 7f", 'h7F, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);
    drp_txn("wr 60", 'h60, 1'b1, 16'h1357, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 60", 'h60, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 50 reset", 'h50, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);

    // Alarm threshold: strictly greater than the limit.
    drp_txn("wr 50", 'h50, 1'b1, 16'h8000, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 50", 'h50, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);
    conv_pulse(6'd0, 16'h8001);
    check("alarm hi", {15'b0, alarm}, {15'b0, ALM_EN});
    conv_pulse(6'd0, 16'h8000);
    conv_pulse(6'd0, 16'h7FFF);
    check("alarm lo", {15'b0, alarm}, 16'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      drp_txn("rand", int'($urandom_range(0, 'h6F)), 1'($urandom_range(0, 1)),
              16'($urandom), 1'($urandom_range(0, 1)),
              6'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 63)), 16'($urandom));
    end

    // Reset during WAIT after a write to 0x40.
    @(negedge clk);
    den = 1'b1; dwe = 1'b1; daddr = 8'h40; di = 16'h1111;
    @(negedge clk);
    den = 1'b0; dwe = 1'b0;
    check("pre-abort cfg_ctrl", cfg_ctrl, 16'h1111);
    #2 rst_n = 1'b0;
    #1 check("abort cfg_ctrl", cfg_ctrl, 16'h9000);
    model_reset();
    n_drdy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (drdy === 1'b1) n_drdy++;
    end
    check("abort drdy count", 16'(n_drdy), 16'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    drp_txn("rd 40 post-abort", 'h40, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);
    drp_txn("rd 10 post-abort", 'h10, 1'b0, 16'h0, 1'b0, 6'd0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
